// File: rtl/input_vc_buffer.sv
// Per-VC input flit FIFO for a router input port: show-ahead head flit for the
// VC controller, one pop per SA grant, one registered credit per accepted pop.
module input_vc_buffer #(
   parameter int DW    = 32,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH+1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   input  logic          pop,
   output logic [DW-1:0] data,
   output logic          valid,
   output logic [1:0]    head_type,
   output logic          credit_out,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          ovf_err,
   output logic          udf_err
);

   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] cnt;
   logic          pop_ok, wr_ok;

   assign valid     = (cnt != '0);
   assign full      = (cnt == CW'(DEPTH));
   assign count     = cnt;
   assign data      = mem[rd_ptr];
   assign head_type = valid ? data[DW-3:DW-4] : 2'b00;

   // A same-cycle pop frees a slot, so a write into a full FIFO is still legal
   assign pop_ok = pop && valid;
   assign wr_ok  = in_valid && (!full || pop_ok);

   // Storage is left out of reset; stale slots are unreachable once cnt is 0
   always_ff @(posedge clk) begin
      if (!rst && wr_ok) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         cnt        <= '0;
         credit_out <= 1'b0;
         ovf_err    <= 1'b0;
         udf_err    <= 1'b0;
      end else begin
         if (wr_ok)  wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_ok, pop_ok})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
         credit_out <= pop_ok;
         if (in_valid && !wr_ok) ovf_err <= 1'b1;
         if (pop && !valid)      udf_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_input_vc_buffer.sv
// Bench for input_vc_buffer: directed vector table followed by a queue-model
// scoreboard over fill, continuous write+pop wrap and random traffic.
module tb_input_vc_buffer;

   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH+1);

   localparam logic [31:0] FA = 32'h1000000A; // HEAD
   localparam logic [31:0] FB = 32'h0000000B; // BODY
   localparam logic [31:0] FC = 32'h2000000C; // TAIL
   localparam logic [31:0] FD = 32'h3000000D; // HEADTAIL
   localparam logic [31:0] FE = 32'h0000000E;
   localparam logic [31:0] FX = 32'h00000001;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          pop = 1'b0;
   logic [DW-1:0] data;
   logic          valid;
   logic [1:0]    head_type;
   logic          credit_out;
   logic [CW-1:0] count;
   logic          full;
   logic          ovf_err;
   logic          udf_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   input_vc_buffer #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .pop(pop),
      .data(data), .valid(valid), .head_type(head_type), .credit_out(credit_out),
      .count(count), .full(full), .ovf_err(ovf_err), .udf_err(udf_err)
   );

   typedef struct {
      logic        rst, iv, pv;
      logic [31:0] din;
      logic        ev;
      logic [31:0] ed;
      logic [1:0]  et;
      int          ec;
      logic        ef, ecr, eovf, eudf;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic r, logic iv, logic pv, logic [31:0] din,
                               logic ev, logic [31:0] ed, logic [1:0] et, int ec,
                               logic ef, logic ecr, logic eovf, logic eudf);
      vec_t v;
      v.rst = r; v.iv = iv; v.pv = pv; v.din = din;
      v.ev = ev; v.ed = ed; v.et = et; v.ec = ec;
      v.ef = ef; v.ecr = ecr; v.eovf = eovf; v.eudf = eudf;
      return v;
   endfunction

   task automatic check(input string name, input int idx, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   logic [31:0] q[$];
   logic        m_ovf, m_udf, m_pop_ok, m_wr_ok;

   initial begin
      // rst iv pv din | valid data type count full credit ovf udf  (state after the edge)
      tbl.push_back(mk(1,0,0,'0, 0,'0,2'b00,0, 0,0,0,0));
      tbl.push_back(mk(0,1,0,FA, 1,FA,2'b01,1, 0,0,0,0));
      tbl.push_back(mk(0,1,0,FB, 1,FA,2'b01,2, 0,0,0,0));
      tbl.push_back(mk(0,1,0,FC, 1,FA,2'b01,3, 0,0,0,0));
      tbl.push_back(mk(0,0,1,'0, 1,FB,2'b00,2, 0,1,0,0));
      tbl.push_back(mk(0,0,1,'0, 1,FC,2'b10,1, 0,1,0,0));
      tbl.push_back(mk(0,0,1,'0, 0,'0,2'b00,0, 0,1,0,0));
      tbl.push_back(mk(0,0,0,'0, 0,'0,2'b00,0, 0,0,0,0));
      // fill, then overflow; oldest flit survives
      tbl.push_back(mk(0,1,0,FA, 1,FA,2'b01,1, 0,0,0,0));
      tbl.push_back(mk(0,1,0,FB, 1,FA,2'b01,2, 0,0,0,0));
      tbl.push_back(mk(0,1,0,FC, 1,FA,2'b01,3, 0,0,0,0));
      tbl.push_back(mk(0,1,0,FD, 1,FA,2'b01,4, 1,0,0,0));
      tbl.push_back(mk(0,1,0,FE, 1,FA,2'b01,4, 1,0,1,0));
      tbl.push_back(mk(0,0,1,'0, 1,FB,2'b00,3, 0,1,1,0));
      // reset, refill, write+pop while full
      tbl.push_back(mk(1,0,0,'0, 0,'0,2'b00,0, 0,0,0,0));
      tbl.push_back(mk(0,1,0,FA, 1,FA,2'b01,1, 0,0,0,0));
      tbl.push_back(mk(0,1,0,FB, 1,FA,2'b01,2, 0,0,0,0));
      tbl.push_back(mk(0,1,0,FC, 1,FA,2'b01,3, 0,0,0,0));
      tbl.push_back(mk(0,1,0,FX, 1,FA,2'b01,4, 1,0,0,0));
      tbl.push_back(mk(0,1,1,FD, 1,FB,2'b00,4, 1,1,0,0));
      tbl.push_back(mk(0,0,1,'0, 1,FC,2'b10,3, 0,1,0,0));
      tbl.push_back(mk(0,0,1,'0, 1,FX,2'b00,2, 0,1,0,0));
      tbl.push_back(mk(0,0,1,'0, 1,FD,2'b11,1, 0,1,0,0));
      tbl.push_back(mk(0,0,1,'0, 0,'0,2'b00,0, 0,1,0,0));
      // underflow, then write+pop while empty
      tbl.push_back(mk(0,0,1,'0, 0,'0,2'b00,0, 0,0,0,1));
      tbl.push_back(mk(0,1,1,FE, 1,FE,2'b00,1, 0,0,0,1));
      // reset with pop asserted at count=2
      tbl.push_back(mk(0,1,0,FB, 1,FE,2'b00,2, 0,0,0,1));
      tbl.push_back(mk(1,0,1,'0, 0,'0,2'b00,0, 0,0,0,0));
      tbl.push_back(mk(0,0,0,'0, 0,'0,2'b00,0, 0,0,0,0));
      // write+pop at count=1 exposes the new flit
      tbl.push_back(mk(0,1,0,FA, 1,FA,2'b01,1, 0,0,0,0));
      tbl.push_back(mk(0,1,1,FB, 1,FB,2'b00,1, 0,1,0,0));
      tbl.push_back(mk(0,0,1,'0, 0,'0,2'b00,0, 0,1,0,0));

      foreach (tbl[i]) begin
         @(negedge clk);
         rst = tbl[i].rst; in_valid = tbl[i].iv; in_data = tbl[i].din; pop = tbl[i].pv;
         @(posedge clk); #1;
         check("valid",  i, valid,      tbl[i].ev);
         if (tbl[i].ev) check("data", i, data, tbl[i].ed);
         check("type",   i, head_type,  tbl[i].et);
         check("count",  i, count,      tbl[i].ec);
         check("full",   i, full,       tbl[i].ef);
         check("credit", i, credit_out, tbl[i].ecr);
         check("ovf",    i, ovf_err,    tbl[i].eovf);
         check("udf",    i, udf_err,    tbl[i].eudf);
      end

      // Scoreboard: 4 fills, 10 write+pop (pointer wrap), then random traffic
      @(negedge clk); rst = 1'b1; in_valid = 1'b0; pop = 1'b0;
      @(posedge clk); #1;
      q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         rst = 1'b0;
         if (c < 4)       begin in_valid = 1'b1; pop = 1'b0; end
         else if (c < 14) begin in_valid = 1'b1; pop = 1'b1; end
         else begin
            in_valid = ($urandom_range(0, 3) != 0);
            pop      = ($urandom_range(0, 2) != 0);
         end
         in_data  = $urandom();
         m_pop_ok = pop && (q.size() > 0);
         m_wr_ok  = in_valid && ((q.size() < DEPTH) || m_pop_ok);
         if (m_pop_ok) begin
            check("sb_data", c, data, q[0]);
            check("sb_type", c, head_type, q[0][DW-3:DW-4]);
            void'(q.pop_front());
         end
         if (m_wr_ok) q.push_back(in_data);
         if (in_valid && !m_wr_ok) m_ovf = 1'b1;
         if (pop && !m_pop_ok)     m_udf = 1'b1;
         @(posedge clk); #1;
         check("sb_count",  c, count,      q.size());
         check("sb_valid",  c, valid,      q.size() > 0);
         check("sb_full",   c, full,       q.size() == DEPTH);
         check("sb_credit", c, credit_out, m_pop_ok);
         check("sb_ovf",    c, ovf_err,    m_ovf);
         check("sb_udf",    c, udf_err,    m_udf);
         if (q.size() == 0) check("sb_type0", c, head_type, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/input_vc_buffer.md
Name: input_vc_buffer

Overview:
- Per-VC input FIFO of a router input port. It sits directly upstream of the input VC controller.
- Accepts flits from the inbound link and exposes the oldest flit show-ahead on `data` / `valid`, which the VC controller uses for routing computation (RC), VC allocation (VA) and switch allocation (SA).
- Pops one flit per switch-allocation grant.
- Returns one credit upstream per popped flit, for credit-based flow control.

Parameters:
- DW, 32, flit width in bits. Flit type field is data[DW-3:DW-4]. Encodings: HEAD=2'b01, BODY=2'b00, TAIL=2'b10, HEADTAIL=2'b11.
- DEPTH, 4, number of flit slots. Must be a power of two, >=2.
- CW, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  flit present on the inbound link this cycle.
- in_data  in  DW  inbound flit.
- pop  in  1  remove the head flit. Driven by the input VC controller's SA grant.
- data  out  DW  head flit, show-ahead. Undefined when valid=0.
- valid  out  1  FIFO not empty.
- head_type  out  2  data[DW-3:DW-4] of the head flit. Forced to 2'b00 when empty.
- credit_out  out  1  one-cycle pulse, one credit returned upstream.
- count  out  CW  current occupancy, 0..DEPTH.
- full  out  1  count==DEPTH.
- ovf_err  out  1  sticky: a write was dropped.
- udf_err  out  1  sticky: pop was asserted while empty.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Pointers, count, credit_out, ovf_err and udf_err are cleared. valid=0, full=0, head_type=0.
  - Memory contents are not cleared.
  - Reset mid-packet discards all buffered flits and emits no credits for them.
  - Upstream restarts with DEPTH credits; no credit-init handshake exists.
- Storage:
  - Circular buffer with wr_ptr and rd_ptr of width log2(DEPTH), plus a separate count register.
  - Pointers wrap DEPTH-1 -> 0.
  - data = mem[rd_ptr], combinational read; no added latency.
- Write:
  - Accepted when in_valid=1 and (full=0 or a pop is accepted in the same cycle).
  - An accepted flit is stored at wr_ptr and wr_ptr increments.
  - in_valid=1 while full with no pop: the flit is dropped, ovf_err is set, and nothing else changes. This is a protocol violation: upstream exceeded its credits.
- Pop:
  - Accepted when pop=1 and valid=1. rd_ptr increments.
  - pop=1 while empty: no state change, udf_err is set.
  - A pop while empty is not combined with a same-cycle write; there is no bypass. A flit written into an empty FIFO becomes visible (valid=1) on the next cycle, giving 1-cycle write-to-valid latency.
- Count update:
  - +1 for write only, -1 for pop only, unchanged for both or neither.
  - Simultaneous write and pop with count==DEPTH: both accepted, count stays DEPTH.
  - Simultaneous write and pop with count==1: after the edge, valid=1 and data is the new flit.
- Credit:
  - credit_out=1 in the cycle after each accepted pop, registered.
  - Back-to-back pops give back-to-back credit pulses; there is no coalescing.
  - Pops that set udf_err produce no credit.
- full, valid and head_type are derived from count and memory; they are not separately registered.
- Flit type is not checked. The FIFO is packet-agnostic and head_type is informational only.

Test Plan:
- Reset, then 3 writes (HEAD 0xA, BODY 0xB, TAIL 0xC), one per cycle, no pop -> valid rises 1 cycle after the first write; data=0xA, head_type=2'b01, count=3, credit_out stays 0.
- From count=3, pop for 3 cycles -> data sequence 0xA, 0xB, 0xC. credit_out pulses 3 cycles, each lagging its pop by 1. count ends at 0, valid=0, head_type=0.
- Fill DEPTH=4, then in_valid=1 with no pop -> flit dropped, ovf_err=1, count=4. A later pop returns the oldest flit, not the dropped one.
- count=4, write 0xD plus pop in the same cycle -> count stays 4, no ovf_err. 0xD is popped 4th. Pointers wrap past 3 correctly over 10 continuous write+pop cycles.
- Empty, pop=1 -> udf_err=1, no credit_out, count=0. Write and pop together while empty -> the write is stored, count=1, udf_err stays set.
- count=2, rst=1 for one cycle while pop=1 -> count=0, valid=0, credit_out=0 on the following cycle, and both error flags cleared.
